// File: rtl/regfile_scoreboard.sv
// MIPS integer register file with per-register pending bits and two combinational read ports.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
module regfile_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  output logic [DATA_W-1:0] Rd1,
  output logic [DATA_W-1:0] Rd2,
  output logic              RsBusy,
  output logic              RtBusy,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic [ADDR_W:0]   PendCount
);

  localparam int unsigned NRegs = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [NRegs];
  logic [NRegs-1:0]  pend_q, pend_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              wr_hit, iss_hit;

  assign wr_hit  = RegWrite && (WrAddr != '0);
  assign iss_hit = IssueEn && (IssueAddr != '0);

  // Issue is applied after write-back so a newer producer stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (wr_hit) begin
      pend_d[WrAddr] = 1'b0;
    end
    if (iss_hit) begin
      pend_d[IssueAddr] = 1'b1;
    end
    count_d = '0;
    for (int unsigned i = 0; i < NRegs; i++) begin
      count_d = count_d + CntW'(pend_d[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_hit) begin
        regs_q[WrAddr] <= WrData;
      end
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign PendCount = count_q;

  always_comb begin
    Rd1    = '0;
    RsBusy = 1'b0;
    if (Rs != '0) begin
      Rd1    = regs_q[Rs];
      RsBusy = pend_q[Rs];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (WrAddr == Rs)) begin
        Rd1    = WrData;
        RsBusy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    Rd2    = '0;
    RtBusy = 1'b0;
    if (Rt != '0) begin
      Rd2    = regs_q[Rt];
      RtBusy = pend_q[Rt];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (WrAddr == Rt)) begin
        Rd2    = WrData;
        RtBusy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, corner sequences,
// and random traffic against an array-based reference model.
module tb_regfile_scoreboard;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  Rs, Rt, WrAddr, IssueAddr;
  logic [31:0] Rd1, Rd2, WrData;
  logic        RsBusy, RtBusy, RegWrite, IssueEn;
  logic [5:0]  PendCount;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_reg  [32];
  logic        m_pend [32];

  always #5 Clk = ~Clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Rs        (Rs),
    .Rt        (Rt),
    .Rd1       (Rd1),
    .Rd2       (Rd2),
    .RsBusy    (RsBusy),
    .RtBusy    (RtBusy),
    .RegWrite  (RegWrite),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .PendCount (PendCount)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rd1;
    logic        e_bs;
    logic [31:0] e_rd2;
    logic        e_bt;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WrAddr != 5'd0 && WrAddr == a) return WrData;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WrAddr != 5'd0 && WrAddr == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  // Drives one cycle of write/issue, advances the model past the edge, then idles the controls.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia);
    RegWrite = we; WrAddr = wa; WrData = wd; IssueEn = ie; IssueAddr = ia;
    @(posedge Clk);
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = '0; m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) begin
        m_reg[wa] = wd; m_pend[wa] = 1'b0;
      end
      if (ie && ia != 0) m_pend[ia] = 1'b1;
    end
    #1;
    RegWrite = 1'b0; IssueEn = 1'b0;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0; Rs = '0; Rt = '0; RegWrite = 1'b0; WrAddr = '0; WrData = '0;
    IssueEn = 1'b0; IssueAddr = '0;
    do_reset();
    do_reset();
    Rs = 5'd5; Rt = 5'd31; #1;
    check("init_rd1", Rd1, 32'h0);
    check("init_busy", {30'h0, RsBusy, RtBusy}, 32'h0);
    check("init_cnt", 32'(PendCount), 32'h0);

    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8, 5'd8,  5'd8,
                32'h0,        1'b1, 32'h0,        1'b1, 6'd1};
    vecs[1] = '{1'b1, 5'd8,  32'h12345678, 1'b0, 5'd0, 5'd0,  5'd8,
                32'h0,        1'b0, 32'h12345678, 1'b0, 6'd0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  5'd0,
                32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3,  5'd0,
                32'h0,        1'b1, 32'h0,        1'b0, 6'd1};
    vecs[4] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd3, 5'd3,  5'd3,
                32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 6'd1};
    vecs[5] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd7, 5'd5,  5'd7,
                32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 6'd2};
    vecs[6] = '{1'b1, 5'd7,  32'h00000001, 1'b0, 5'd0, 5'd3,  5'd7,
                32'hA5A5A5A5, 1'b1, 32'h00000001, 1'b0, 6'd1};
    vecs[7] = '{1'b1, 5'd10, 32'h00000055, 1'b0, 5'd0, 5'd10, 5'd10,
                32'h00000055, 1'b0, 32'h00000055, 1'b0, 6'd1};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3,  5'd5,
                32'hA5A5A5A5, 1'b1, 32'hDEADBEEF, 1'b0, 6'd1};

    for (int v = 0; v < 9; v++) begin
      step(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ie, vecs[v].ia);
      Rs = vecs[v].rs; Rt = vecs[v].rt; #1;
      check($sformatf("vec%0d_rd1", v), Rd1, vecs[v].e_rd1);
      check($sformatf("vec%0d_rsbusy", v), 32'(RsBusy), 32'(vecs[v].e_bs));
      check($sformatf("vec%0d_rd2", v), Rd2, vecs[v].e_rd2);
      check($sformatf("vec%0d_rtbusy", v), 32'(RtBusy), 32'(vecs[v].e_bt));
      check($sformatf("vec%0d_cnt", v), 32'(PendCount), 32'(vecs[v].e_cnt));
    end

    // Bypass: r9 pending and never written, so the stored value is still 0.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    Rs = 5'd9; RegWrite = 1'b1; WrAddr = 5'd9; WrData = 32'h0000CAFE; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_rd1", Rd1, 32'h0000CAFE);
    check("byp_same_busy", 32'(RsBusy), 32'h0);
`else
    check("byp_same_rd1", Rd1, 32'h0);
    check("byp_same_busy", 32'(RsBusy), 32'h1);
`endif
    step(1'b1, 5'd9, 32'h0000CAFE, 1'b0, 5'd0);
    #1;
    check("byp_next_rd1", Rd1, 32'h0000CAFE);
    check("byp_next_busy", 32'(RsBusy), 32'h0);

    // Reset wins over a same-cycle write and issue.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    Rst_n = 1'b0;
    step(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6);
    Rst_n = 1'b1;
    Rs = 5'd5; Rt = 5'd6; #1;
    check("rst_rd1", Rd1, 32'h0);
    check("rst_rd2", Rd2, 32'h0);
    check("rst_busy", {30'h0, RsBusy, RtBusy}, 32'h0);
    check("rst_cnt", 32'(PendCount), 32'h0);

    for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
    #1;
    check("fill_cnt", 32'(PendCount), 32'd31);
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'hC0DE0000 | 32'(i * 7), 1'b0, 5'd0);
    #1;
    check("drain_cnt", 32'(PendCount), 32'd0);
    for (int i = 1; i < 32; i++) begin
      Rs = 5'(i); Rt = 5'((i % 31) + 1); #1;
      check($sformatf("drain_rd1_r%0d", i), Rd1, 32'hC0DE0000 | 32'(i * 7));
      check($sformatf("drain_rd2_r%0d", i), Rd2, 32'hC0DE0000 | 32'(((i % 31) + 1) * 7));
      check($sformatf("drain_busy_r%0d", i), {30'h0, RsBusy, RtBusy}, 32'h0);
    end

    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic        we, ie;
      logic [4:0]  wa, ia;
      logic [31:0] wd;
      we = 1'($urandom); ie = 1'($urandom);
      wa = 5'($urandom_range(0, 7)); ia = 5'($urandom_range(0, 7));
      wd = $urandom;
      Rs = 5'($urandom_range(0, 7)); Rt = 5'($urandom_range(0, 7));
      RegWrite = we; WrAddr = wa; WrData = wd; IssueEn = ie; IssueAddr = ia;
      #1;
      check("rnd_rd1", Rd1, exp_rd(Rs));
      check("rnd_rd2", Rd2, exp_rd(Rt));
      check("rnd_busy", {30'h0, RsBusy, RtBusy}, {30'h0, exp_busy(Rs), exp_busy(Rt)});
      check("rnd_cnt", 32'(PendCount), 32'(model_count()));
      step(we, wa, wd, ie, ia);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
